// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared FSM states, error codes and frame constants for the boot loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_COUNT,
        ERR_CSUM,
        ERR_TIMEOUT
    } err_e;

    localparam int HDR_LEN = 2;
    localparam int CNT_W   = 8 * HDR_LEN;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, instruction-memory write port and core run/status signals.
interface prog_loader_if #(parameter int ADDR_W = 16);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst_f;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, im_we, im_addr, im_wdata, cpu_rst_f, done, err, err_code
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, im_we, im_addr, im_wdata, cpu_rst_f, done, err, err_code
    );

endinterface

// File: rtl/prog_loader_word_packer.sv
// word_packer: shifts big-endian bytes into 32-bit words; word_valid pulses one clock after the 4th byte.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  din,
    output logic        word_valid,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;
    logic        word_valid_q, word_valid_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d        = en ? cnt_q + 2'd1 : cnt_q;
        sr_d         = en ? {sr_q[15:0], din} : sr_q;
        word_valid_d = en && cnt_q == 2'd3;
        word_d       = word_valid_d ? {sr_q, din} : word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            sr_q         <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word       = word_q;
    assign last_byte  = cnt_q == 2'd3;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: frames a host byte stream into instruction memory and releases the core on a good checksum.
// Define PROG_LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle clocks.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int MAX_WORDS   = 1024,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic          clk,
    input logic          rst_f,
    prog_loader_if.master bus
);

    localparam int CW = (ADDR_W > CNT_W ? ADDR_W : CNT_W) + 1;

    if (MAX_WORDS > (1 << ADDR_W) || TIMEOUT_CYC < 1) begin : g_cfg_err
        $error("prog_loader: MAX_WORDS must fit ADDR_W and TIMEOUT_CYC must be positive");
    end

    state_e            state_q, state_d;
    err_e              err_code_q, err_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              rx_ready_q, rx_ready_d;
    logic              cpu_rst_f_q, cpu_rst_f_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept, pack_en, last_word;
    logic              word_valid, last_byte;
    logic [31:0]       word;

    assign accept    = bus.rx_valid && rx_ready_q;
    assign pack_en   = accept && state_q == S_DATA;
    assign last_word = CW'(idx_q) + CW'(1) == CW'(cnt_q);

    word_packer u_packer (
        .clk       (clk),
        .rst       (rst_f),
        .en        (pack_en),
        .din       (bus.rx_data),
        .word_valid(word_valid),
        .word      (word),
        .last_byte (last_byte)
    );

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_q, idle_d;
    logic          waiting;
    assign waiting = state_q inside {S_CNT_LO, S_DATA, S_CSUM};
`endif

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        cnt_d      = cnt_q;
        csum_d     = accept ? csum_q ^ bus.rx_data : csum_q;
        idx_d      = word_valid ? idx_q + 1'b1 : idx_q;
        case (state_q)
            S_CNT_HI: if (accept) begin
                cnt_d   = {bus.rx_data, cnt_q[7:0]};
                state_d = S_CNT_LO;
            end
            S_CNT_LO: if (accept) begin
                cnt_d      = {cnt_q[CNT_W-1:8], bus.rx_data};
                state_d    = 32'(cnt_d) > MAX_WORDS ? S_ERR : cnt_d == '0 ? S_CSUM : S_DATA;
                err_code_d = 32'(cnt_d) > MAX_WORDS ? ERR_COUNT : err_code_q;
            end
            S_DATA: if (word_valid && last_word) state_d = S_CSUM;
            S_CSUM: if (accept) begin
                state_d    = bus.rx_data == csum_q ? S_RUN : S_ERR;
                err_code_d = bus.rx_data == csum_q ? err_code_q : ERR_CSUM;
            end
            default: ;
        endcase
`ifdef PROG_LOADER_TIMEOUT_EN
        idle_d = (accept || !waiting) ? '0 : idle_q + 1'b1;
        if (waiting && !accept && idle_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d    = S_ERR;
            err_code_d = ERR_TIMEOUT;
        end
`endif
        // Drop ready while the final word is written so the checksum byte is never taken in S_DATA.
        rx_ready_d  = state_d inside {S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM} &&
                      !(pack_en && last_byte && last_word);
        cpu_rst_f_d = state_q == S_RUN;
        done_d      = state_d == S_RUN;
        err_d       = state_d == S_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q     <= S_CNT_HI;
            err_code_q  <= ERR_NONE;
            cnt_q       <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            rx_ready_q  <= 1'b0;
            cpu_rst_f_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            rx_ready_q  <= rx_ready_d;
            cpu_rst_f_q <= cpu_rst_f_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef PROG_LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst_f) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`endif

    assign bus.rx_ready  = rx_ready_q;
    assign bus.im_we     = word_valid;
    assign bus.im_addr   = idx_q;
    assign bus.im_wdata  = word;
    assign bus.cpu_rst_f = cpu_rst_f_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule
